// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between the decode-issue stage and the
// register scoreboard. The master drives instruction and writeback info;
// the slave returns issue_ready and pending-state summaries.
interface reg_scoreboard_if #(
    parameter int REG_NUM   = 32,
    parameter int REG_WIDTH = 5
);
    logic                 issue_valid;
    logic                 issue_ready;
    logic                 issue_rs1_en;
    logic [REG_WIDTH-1:0] issue_rs1_addr;
    logic                 issue_rs2_en;
    logic [REG_WIDTH-1:0] issue_rs2_addr;
    logic                 issue_rd_en;
    logic [REG_WIDTH-1:0] issue_rd_addr;
    logic                 wb_valid;
    logic [REG_WIDTH-1:0] wb_addr;
    logic                 flush;
    logic [REG_NUM-1:0]   busy_vec;
    logic                 idle;
    logic                 err;

    modport master (
        output issue_valid, issue_rs1_en, issue_rs1_addr, issue_rs2_en,
               issue_rs2_addr, issue_rd_en, issue_rd_addr, wb_valid, wb_addr,
               flush,
        input  issue_ready, busy_vec, idle, err
    );

    modport slave (
        input  issue_valid, issue_rs1_en, issue_rs1_addr, issue_rs2_en,
               issue_rs2_addr, issue_rd_en, issue_rd_addr, wb_valid, wb_addr,
               flush,
        output issue_ready, busy_vec, idle, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one saturating pending-write counter per architectural
// register (r0 excluded). Issue is stalled on RAW hazards against registered
// pending state and when the destination counter is full.

// Per-register pending counter. inc comes from an issue fire, dec from a
// writeback. A decrement is only honoured on a non-zero count; a writeback
// that finds the count at zero raises err_hit instead. clr (flush) wins over
// both, and the caller already masks dec while clr is high.
module reg_sb_cnt #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 err_hit
);
    logic [CNT_WIDTH-1:0] cnt_nxt;

    // Next count: apply the decrement first so inc+dec at max cannot overflow,
    // and inc+dec at zero leaves one write outstanding.
    always_comb begin
        cnt_nxt = cnt;
        err_hit = dec && (cnt == '0);
        if (dec && (cnt != '0))
            cnt_nxt = cnt_nxt - CNT_WIDTH'(1);
        if (inc)
            cnt_nxt = cnt_nxt + CNT_WIDTH'(1);
    end

    // Counter register; flush clears all outstanding writes.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
endmodule

module reg_scoreboard #(
    parameter int REG_NUM   = 32,
    parameter int REG_WIDTH = 5,
    parameter int CNT_WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);
    typedef struct packed {
        logic                 valid;
        logic                 rs1_en;
        logic [REG_WIDTH-1:0] rs1;
        logic                 rs2_en;
        logic [REG_WIDTH-1:0] rs2;
        logic                 rd_en;
        logic [REG_WIDTH-1:0] rd;
    } issue_req_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_WIDTH-1:0] addr;
    } wb_req_t;

    issue_req_t req;
    wb_req_t    wb;

    assign req = '{valid:  sb.issue_valid,
                   rs1_en: sb.issue_rs1_en,  rs1: sb.issue_rs1_addr,
                   rs2_en: sb.issue_rs2_en,  rs2: sb.issue_rs2_addr,
                   rd_en:  sb.issue_rd_en,   rd:  sb.issue_rd_addr};
    assign wb  = '{valid: sb.wb_valid, addr: sb.wb_addr};

    logic [REG_NUM-1:0][CNT_WIDTH-1:0] pending;
    logic [REG_NUM-1:0]                busy;
    logic [REG_NUM-1:0]                full;
    logic [REG_NUM-1:0]                err_hit_vec;
    logic                              fire;
    logic                              raw1, raw2, sat;
    logic                              err_q;

    // Hazard/stall equation on registered pending only: the regfile returns
    // the old value on read-during-write, so a same-cycle writeback must not
    // release a dependent read.
    always_comb begin
        raw1 = req.rs1_en && (req.rs1 != '0) && busy[req.rs1];
        raw2 = req.rs2_en && (req.rs2 != '0) && busy[req.rs2];
        sat  = req.rd_en  && (req.rd  != '0) && full[req.rd];
    end

    assign sb.issue_ready = !sb.flush && !raw1 && !raw2 && !sat;
    assign fire           = req.valid && sb.issue_ready;

    // One counter per register; r0 is hard-wired idle and never errors.
    for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign pending[i]     = '0;
            assign err_hit_vec[i] = 1'b0;
        end else begin : g_cnt
            logic inc, dec;
            assign inc = fire && req.rd_en && (req.rd == REG_WIDTH'(i));
            assign dec = wb.valid && !sb.flush && (wb.addr == REG_WIDTH'(i));

            reg_sb_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .clr     (sb.flush),
                .inc     (inc),
                .dec     (dec),
                .cnt     (pending[i]),
                .err_hit (err_hit_vec[i])
            );
        end
        assign busy[i] = |pending[i];
        assign full[i] = &pending[i];
    end

    // Sticky writeback-without-pending error; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (|err_hit_vec)
            err_q <= 1'b1;
    end

    assign sb.busy_vec = busy;
    assign sb.idle     = ~|busy;
    assign sb.err      = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.REG_NUM(32), .REG_WIDTH(5)) bus ();

    reg_scoreboard #(.REG_NUM(32), .REG_WIDTH(5), .CNT_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.issue_valid    = 1'b0;
        bus.issue_rs1_en   = 1'b0;
        bus.issue_rs1_addr = '0;
        bus.issue_rs2_en   = 1'b0;
        bus.issue_rs2_addr = '0;
        bus.issue_rd_en    = 1'b0;
        bus.issue_rd_addr  = '0;
        bus.wb_valid       = 1'b0;
        bus.wb_addr        = '0;
        bus.flush          = 1'b0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        bus.issue_valid   = 1'b1;
        bus.issue_rd_en   = 1'b1;
        bus.issue_rd_addr = rd;
    endtask

    task automatic wb(input logic [4:0] a);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        tick();
        tick();
        check("rst_busy",  bus.busy_vec, 32'h0);
        check("rst_idle",  bus.idle, 1);
        check("rst_err",   bus.err, 0);
        check("rst_ready", bus.issue_ready, 1);
        reset = 1'b0;

        // 1: RAW on rd=5, cleared one cycle after writeback
        issue_rd(5);
        #1 check("t1_ready_first", bus.issue_ready, 1);
        tick();
        quiet();
        bus.issue_valid = 1'b1; bus.issue_rs1_en = 1'b1; bus.issue_rs1_addr = 5;
        #1 check("t1_raw_stall", bus.issue_ready, 0);
        check("t1_busy5", bus.busy_vec, 32'h0000_0020);
        check("t1_not_idle", bus.idle, 0);
        wb(5);
        #1 check("t1_no_bypass", bus.issue_ready, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1 check("t1_ready_after_wb", bus.issue_ready, 1);
        check("t1_busy_clear", bus.busy_vec, 32'h0);
        check("t1_idle", bus.idle, 1);
        quiet();

        // rs2 hazard path
        issue_rd(20);
        tick();
        quiet();
        bus.issue_valid = 1'b1; bus.issue_rs2_en = 1'b1; bus.issue_rs2_addr = 20;
        #1 check("rs2_stall", bus.issue_ready, 0);
        bus.issue_rs2_en = 1'b0;
        #1 check("rs2_disabled", bus.issue_ready, 1);
        bus.issue_valid = 1'b0;
        wb(20);
        tick();
        quiet();

        // 2: register 0 is never tracked
        issue_rd(0);
        bus.issue_rs1_en = 1'b1; bus.issue_rs1_addr = 0;
        wb(0);
        #1 check("t2_ready_r0", bus.issue_ready, 1);
        tick();
        check("t2_busy", bus.busy_vec, 32'h0);
        check("t2_ready", bus.issue_ready, 1);
        check("t2_err", bus.err, 0);
        quiet();

        // 3: saturate r7 at 3, then drain
        issue_rd(7);
        tick(); tick(); tick();
        #1 check("t3_sat_stall", bus.issue_ready, 0);
        check("t3_busy7", bus.busy_vec, 32'h0000_0080);
        tick();
        check("t3_no_overflow", bus.busy_vec, 32'h0000_0080);
        quiet();
        wb(7);
        tick();
        check("t3_not_full", bus.issue_ready, 1);
        tick();
        check("t3_busy_after2", bus.busy_vec, 32'h0000_0080);
        tick();
        check("t3_drained", bus.busy_vec, 32'h0);
        check("t3_err", bus.err, 0);
        quiet();

        // 4: same-cycle inc+dec on r9 holds count
        issue_rd(9);
        tick();
        wb(9);
        #1 check("t4_ready", bus.issue_ready, 1);
        tick();
        quiet();
        check("t4_held", bus.busy_vec, 32'h0000_0200);
        wb(9);
        tick();
        quiet();
        check("t4_cleared", bus.busy_vec, 32'h0);
        check("t4_err", bus.err, 0);

        // 5: flush with concurrent issue and writeback
        issue_rd(3);  tick();
        issue_rd(4);  tick();
        issue_rd(12); tick();
        quiet();
        check("t5_pending", bus.busy_vec, 32'h0000_1018);
        issue_rd(6);
        wb(3);
        bus.flush = 1'b1;
        #1 check("t5_flush_ready", bus.issue_ready, 0);
        tick();
        quiet();
        check("t5_busy", bus.busy_vec, 32'h0);
        check("t5_idle", bus.idle, 1);
        check("t5_err", bus.err, 0);

        // 6: sticky err survives flush, cleared by reset
        wb(10);
        tick();
        quiet();
        check("t6_err_set", bus.err, 1);
        check("t6_busy", bus.busy_vec, 32'h0);
        bus.flush = 1'b1;
        tick();
        quiet();
        check("t6_err_flush", bus.err, 1);
        reset = 1'b1;
        tick();
        check("t6_err_reset", bus.err, 0);
        reset = 1'b0;

        // inc and dec at zero on r11: err set and one write left outstanding
        issue_rd(11);
        wb(11);
        tick();
        quiet();
        check("z_err", bus.err, 1);
        check("z_busy", bus.busy_vec, 32'h0000_0800);

        // reset overrides a concurrent issue
        issue_rd(13);
        reset = 1'b1;
        tick();
        quiet();
        reset = 1'b0;
        check("rst_over_busy", bus.busy_vec, 32'h0);
        check("rst_over_err", bus.err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks outstanding register-file writes for the in-order core.
- Sits beside the register file between decode/issue and writeback.
- Stalls issue on read-after-write hazards and on counter saturation. Clears pending state when writeback retires or a flush squashes the pipeline.
- Holds a per-register pending-write counter, so multiple in-flight writes to the same register are tracked.

Parameters:
REG_NUM, 32, number of architectural registers.
REG_WIDTH, 5, register address width (log2 REG_NUM).
CNT_WIDTH, 2, per-register pending counter width; max pending = 2^CNT_WIDTH-1.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
issue_valid  in  1  decode presents an instruction this cycle.
issue_ready  out  1  instruction may issue this cycle (combinational).
issue_rs1_en  in  1  instruction reads rs1.
issue_rs1_addr  in  REG_WIDTH  rs1 index.
issue_rs2_en  in  1  instruction reads rs2.
issue_rs2_addr  in  REG_WIDTH  rs2 index.
issue_rd_en  in  1  instruction writes rd.
issue_rd_addr  in  REG_WIDTH  rd index.
wb_valid  in  1  writeback port commits a write this cycle (same strobe as regfile rw_en).
wb_addr  in  REG_WIDTH  writeback destination.
flush  in  1  squash all in-flight instructions.
busy_vec  out  REG_NUM  bit i = 1 when pending[i] != 0 (registered state).
idle  out  1  all pending counters zero.
err  out  1  sticky; set on a writeback to a register with pending = 0.

Behaviour:
- State: pending[REG_NUM] of CNT_WIDTH bits, plus sticky err.
- Reset: all pending = 0, err = 0. Outputs during and after reset: busy_vec = 0, idle = 1, err = 0. issue_ready follows the hazard equation (1 after reset unless flush is high).
- Register 0 is never tracked.
  - rs addr 0 never hazards.
  - rd addr 0 never increments.
  - wb_addr 0 is ignored and never sets err.
- Hazards use registered pending only. There is no same-cycle bypass, because the regfile returns the old value on a read-during-write.
- raw1 = issue_rs1_en && rs1 != 0 && pending[rs1] != 0. raw2 is defined the same way for rs2.
- sat = issue_rd_en && rd != 0 && pending[rd] == max.
- issue_ready = !flush && !raw1 && !raw2 && !sat. It is independent of issue_valid.
- Issue fire = issue_valid && issue_ready. On fire with issue_rd_en && rd != 0, pending[rd] increments at the next edge.
- Writeback: when wb_valid && wb_addr != 0:
  - if pending[wb_addr] != 0, it decrements at the next edge;
  - otherwise the counter stays 0 and err is set.
- Same register, same cycle fire-increment and wb-decrement: net unchanged. This also applies at max (decrement applied first, so no overflow) and at 0 (decrement valid only if count > 0 before the edge; if count is 0, err is set and the counter becomes 1).
- Different registers in the same cycle are updated independently.
- Flush has priority over everything in its cycle:
  - all pending cleared at the next edge;
  - issue_ready = 0;
  - any wb in that cycle is ignored (no err).
  - err is not cleared; only reset clears err.
- Latency:
  - an issue is visible in busy_vec/hazards one cycle after fire;
  - a writeback clears the hazard one cycle after wb_valid;
  - a dependent instruction therefore issues at the earliest in the cycle after writeback.
- Reset asserted mid-operation overrides flush, issue and wb in that cycle.
- busy_vec and idle are combinational from registered pending only.

Test Plan:
1. Reset then issue rd=5 (valid, ready=1). Next cycle issue rs1=5 -> issue_ready=0, busy_vec[5]=1. wb_valid addr=5 -> one cycle later ready=1, busy_vec=0, idle=1.
2. Issue rd=0, then rs1=0 and wb addr=0 -> busy_vec stays 0, ready stays 1, err=0.
3. Issue rd=7 three times (CNT_WIDTH=2) -> pending[7]=3. A fourth issue rd=7 sees ready=0. Three writebacks to 7 -> busy_vec[7]=0 after the third.
4. pending[9]=1; same cycle issue rd=9 (rs unused) and wb addr=9 -> pending[9] stays 1. A following wb 9 -> 0.
5. Pending on regs 3, 4, 12; assert flush with simultaneous issue rd=6 and wb addr=3 -> ready=0 during flush. Next cycle busy_vec=0, idle=1, err=0, reg 6 not busy.
6. From reset, wb_valid addr=10 -> err=1 next cycle and stays 1 through a flush. Assert reset -> err=0.
